tia_hbiphase_clock: RTL and testbench



---
 rtl/tia_pkg.sv | 13 +
 rtl/tia_hbiphase_clock.sv | 72 +++++++
 tb/tb_tia_hbiphase_clock.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tia_pkg.sv
// Shared TIA constants: horizontal phase counter width and phase encodings.
package tia_pkg;

  localparam int TIA_HPHASE_W = 2;

  typedef logic [TIA_HPHASE_W-1:0] hphase_t;

  localparam hphase_t HPH_PHI2  = 2'd0;
  localparam hphase_t HPH_DEAD1 = 2'd1;
  localparam hphase_t HPH_PHI1  = 2'd2;
  localparam hphase_t HPH_DEAD2 = 2'd3;

endpackage

// File: rtl/tia_hbiphase_clock.sv
// TIA horizontal two-phase non-overlapping clock (hphi1/hphi2), color clock / 4, plus rsynl.
// Optional falling-edge protocol checker: define TIA_HBIPHASE_OVERLAP_CHECK_EN.
module tia_hbiphase_clock
  import tia_pkg::*;
(
  input  logic clk,
  input  logic rsyn,
  output logic hphi1,
  output logic hphi2,
  output logic rsynl
);

  hphase_t r_ph;
  hphase_t w_ph_nxt;
  logic    r_hphi1;
  logic    r_hphi2;
  logic    r_rsynl;

  assign w_ph_nxt = r_ph + 2'd1;

  // Reset parks the counter on the last dead phase so the first edge after release emits hphi2.
  always_ff @(posedge clk or posedge rsyn) begin
    if (rsyn) begin
      r_ph    <= HPH_DEAD2;
      r_hphi1 <= 1'b0;
      r_hphi2 <= 1'b0;
      r_rsynl <= 1'b1;
    end else begin
      r_ph    <= w_ph_nxt;
      r_hphi1 <= (w_ph_nxt == HPH_PHI1);
      r_hphi2 <= (w_ph_nxt == HPH_PHI2);
      r_rsynl <= 1'b0;
    end
  end

  assign hphi1 = r_hphi1;
  assign hphi2 = r_hphi2;
  assign rsynl = r_rsynl;

`ifdef TIA_HBIPHASE_OVERLAP_CHECK_EN
  logic        r_chk_p1;
  logic        r_chk_p2;
  logic        r_chk_seen;
  int unsigned r_chk_cnt;

  // r_chk_cnt counts samples since the last hphi2 pulse; a 4-clk period means 3 gaps.
  always @(negedge clk) begin
    if (rsyn) begin
      r_chk_p1   <= 1'b0;
      r_chk_p2   <= 1'b0;
      r_chk_seen <= 1'b0;
      r_chk_cnt  <= 0;
    end else begin
      if (hphi1 && hphi2)
        $fatal(1, "tia_hbiphase_clock: hphi1 and hphi2 overlap");
      if ((hphi1 && r_chk_p1) || (hphi2 && r_chk_p2))
        $fatal(1, "tia_hbiphase_clock: phase high for more than one clk");
      if (hphi2) begin
        if (r_chk_seen && (r_chk_cnt != 3))
          $fatal(1, "tia_hbiphase_clock: phase period is not 4 clks");
        r_chk_seen <= 1'b1;
        r_chk_cnt  <= 0;
      end else begin
        r_chk_cnt <= r_chk_cnt + 1;
      end
      r_chk_p1 <= hphi1;
      r_chk_p2 <= hphi2;
    end
  end
`endif

endmodule

// File: tb/tb_tia_hbiphase_clock.sv
// Directed bench for tia_hbiphase_clock: reset, release sequence, free-run, async reset, coincident release.
module tb_tia_hbiphase_clock;

  logic clk;
  logic rsyn;
  logic hphi1;
  logic hphi2;
  logic rsynl;

  int vec_cnt;
  int err_cnt;

  tia_hbiphase_clock u_dut (
    .clk   (clk),
    .rsyn  (rsyn),
    .hphi1 (hphi1),
    .hphi2 (hphi2),
    .rsynl (rsynl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {hphi1,hphi2,rsynl} for edge En after release (n counted from 1).
  function automatic logic [2:0] exp_after(input int n);
    case ((n - 1) % 4)
      0:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  initial begin
    int n1;
    int n2;
    int ovl;
    int adj;
    logic p1;
    logic p2;
    bit found;
    int first;
    logic [2:0] smp [12];

    vec_cnt = 0;
    err_cnt = 0;
    rsyn    = 1'b1;

    // Reset hold.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", {29'd0, hphi1, hphi2, rsynl}, 32'b001);
    end

    // Release and first five edges.
    rsyn = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      chk($sformatf("release_E%0d", e), {29'd0, hphi1, hphi2, rsynl}, {29'd0, exp_after(e)});
    end

    // Free run 1000 clks (edges E6..E1005).
    n1 = 0; n2 = 0; ovl = 0; adj = 0;
    p1 = hphi1; p2 = hphi2;
    for (int e = 6; e <= 1005; e++) begin
      @(negedge clk);
      if (hphi1) n1++;
      if (hphi2) n2++;
      if (hphi1 && hphi2) ovl++;
      if ((hphi1 && p1) || (hphi2 && p2)) adj++;
      if ({hphi1, hphi2, rsynl} !== exp_after(e))
        chk($sformatf("freerun_E%0d", e), {29'd0, hphi1, hphi2, rsynl}, {29'd0, exp_after(e)});
      p1 = hphi1; p2 = hphi2;
    end
    chk("freerun_phi1_count", n1, 250);
    chk("freerun_phi2_count", n2, 250);
    chk("freerun_overlap", ovl, 0);
    chk("freerun_adjacent", adj, 0);

    // Async reset while hphi1 is high, between clock edges.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (hphi1) found = 1'b1;
    end
    chk("find_phi1", {31'd0, found}, 32'd1);
    #2 rsyn = 1'b1;
    #1;
    chk("async_rst_outputs", {29'd0, hphi1, hphi2, rsynl}, 32'b001);
    @(negedge clk);
    chk("async_rst_hold", {29'd0, hphi1, hphi2, rsynl}, 32'b001);
    rsyn = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk($sformatf("restart_E%0d", e), {29'd0, hphi1, hphi2, rsynl}, {29'd0, exp_after(e)});
    end

    // Release coincident with a rising edge: E1 may be that edge or the next.
    rsyn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    rsyn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      smp[i] = {hphi1, hphi2, rsynl};
    end
    first = -1;
    for (int i = 1; i >= 0; i--)
      if (smp[i] == 3'b010) first = i;
    chk("coinc_first_within_2", {31'd0, (first == 0 || first == 1)}, 32'd1);
    if (first == 1)
      chk("coinc_pre_reset", {29'd0, smp[0]}, 32'b001);
    if (first >= 0)
      for (int i = 0; i < 12 - first; i++)
        chk($sformatf("coinc_E%0d", i + 1), {29'd0, smp[first + i]}, {29'd0, exp_after(i + 1)});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
